spi_mem_fsm: RTL and testbench
==============================

SPI_MEM_FSM -- requirements
Module: spi_mem_fsm

Interface
REQ-001 SHALL have parameter: width, 8, bits per SPI transfer phase (address+R/W byte, data byte).
REQ-002 SHALL have port: clk  input  1  FPGA clock; all state changes on posedge clk.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: chipSelectN  input  1  conditioned SPI chip select, active low.
REQ-005 SHALL have port: sclkPosEdge  input  1  single-clk pulse marking a serial-clock rising edge.
REQ-006 SHALL have port: sclkNegEdge  input  1  single-clk pulse marking a serial-clock falling edge.
REQ-007 SHALL have port: readWrite  input  1  shift-register parallel-out LSB; 1 = read, 0 = write.
REQ-008 SHALL have port: addrLatchEnable  output  1  one-cycle strobe capturing the address byte.
REQ-009 SHALL have port: shiftRegLoad  output  1  one-cycle parallel-load strobe to the shift register.
REQ-010 SHALL have port: misoBufferEnable  output  1  drives MISO tri-state enable.
REQ-011 SHALL have port: dataMemWriteEnable  output  1  one-cycle data-memory write strobe.

Function
REQ-012 SHALL implement states IDLE, GET_ADDR, GOT_ADDR, READ_LOAD, READ_SHIFT, WRITE_RECV, WRITE_COMMIT, DONE.
REQ-013 IDLE: chipSelectN low -> GET_ADDR next clk, bit counter cleared to 0.
REQ-014 GET_ADDR: counter increments on each sclkPosEdge; on the width-th pulse -> GOT_ADDR next clk.
REQ-015 GOT_ADDR: addrLatchEnable high this cycle only; readWrite sampled; 1 -> READ_LOAD, 0 -> WRITE_RECV; counter cleared.
REQ-016 READ_LOAD: shiftRegLoad high this cycle only; -> READ_SHIFT next clk.
REQ-017 READ_SHIFT: misoBufferEnable high throughout; counter increments on sclkNegEdge; on width-th pulse -> DONE.
REQ-018 WRITE_RECV: counter increments on sclkPosEdge; on width-th pulse -> WRITE_COMMIT.
REQ-019 WRITE_COMMIT: dataMemWriteEnable high this cycle only; -> DONE.
REQ-020 DONE: all outputs low; stays until chipSelectN high, then -> IDLE.
REQ-021 chipSelectN high in any state other than IDLE SHALL force IDLE next clk; no strobe asserted in that cycle (abort).
REQ-022 Edge pulses SHALL be ignored in states that do not count them (IDLE, GOT_ADDR, READ_LOAD, WRITE_COMMIT, DONE).
REQ-023 Counter width SHALL be $clog2(width+1); counter never exceeds width; no wrap-around.
REQ-024 Outputs SHALL be Moore (decoded from registered state only); misoBufferEnable glitch-free.
REQ-025 Simultaneous sclkPosEdge and sclkNegEdge SHALL be treated per-state: only the edge the state counts has effect.

Reset
REQ-026 reset high at posedge clk SHALL force IDLE, counter 0, all four outputs 0 on the following cycle, overriding chipSelectN and edge pulses.
REQ-027 reset mid-transfer SHALL abort without emitting addrLatchEnable, shiftRegLoad or dataMemWriteEnable.

Structure
REQ-028 State encoding constants and counter-width function SHALL live in shared package spi_pkg.
REQ-029 Bit counting SHALL be factored into one sub-module, spi_bit_counter (clear, increment, done-at-width).
REQ-030 Implementation SHALL be single-clock, no latches, no derived clocks.

Verification
REQ-031 Write: CS low, 8 posedges with readWrite=0 at GOT_ADDR, 8 more posedges -> addrLatchEnable 1 cycle, dataMemWriteEnable exactly 1 cycle after 16th posedge, then DONE.
REQ-032 Read: CS low, 8 posedges, readWrite=1 -> addrLatchEnable then shiftRegLoad on consecutive cycles; misoBufferEnable high until 8th negedge, then low.
REQ-033 Abort: CS high after 5 address posedges -> IDLE next clk, no strobes; next transfer completes normally.
REQ-034 Reset asserted during READ_SHIFT after 3 negedges -> all outputs 0 next cycle, state IDLE, counter 0.
REQ-035 Spurious edges: negedge pulses in GET_ADDR and posedge pulses in READ_SHIFT -> counter unchanged.
REQ-036 CS held low after DONE with further edges -> remains DONE, no strobes, until CS rises.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding and bit-counter width helper for the SPI memory FSM
package spi_pkg;
   typedef enum logic [2:0] {
      S_IDLE, S_GET_ADDR, S_GOT_ADDR, S_READ_LOAD,
      S_READ_SHIFT, S_WRITE_RECV, S_WRITE_COMMIT, S_DONE
   } state_t;
   function automatic int cnt_w(input int w);
      return $clog2(w + 1);
   endfunction
endpackage

// File: rtl/spi_bit_counter.sv
// spi_bit_counter: saturating bit counter with clear, increment and last-pulse detect
// ports: clk, reset (sync, active high), clear_i, inc_i, last_o (this increment reaches width)
module spi_bit_counter
   import spi_pkg::*;
#(
   parameter int width = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   input  logic inc_i,
   output logic last_o
);
   localparam int W = cnt_w(width);
   localparam logic [W-1:0] LAST = W'(width - 1);
   localparam logic [W-1:0] FULL = W'(width);
   logic [W-1:0] cnt_q;
   assign last_o = inc_i && cnt_q == LAST;
   always_ff @(posedge clk) begin
      if (reset || clear_i) cnt_q <= '0;
      else if (inc_i && cnt_q != FULL) cnt_q <= cnt_q + 1'b1;
   end
endmodule

// File: rtl/spi_mem_fsm.sv
// spi_mem_fsm: SPI slave transaction controller for a small data memory
// ports: clk, reset (sync, active high), chipSelectN, sclkPosEdge/sclkNegEdge (edge pulses),
//        readWrite (1 = read); strobes addrLatchEnable, shiftRegLoad, dataMemWriteEnable,
//        and misoBufferEnable held through the read shift phase
module spi_mem_fsm
   import spi_pkg::*;
#(
   parameter int width = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic chipSelectN,
   input  logic sclkPosEdge,
   input  logic sclkNegEdge,
   input  logic readWrite,
   output logic addrLatchEnable,
   output logic shiftRegLoad,
   output logic misoBufferEnable,
   output logic dataMemWriteEnable
);
   state_t state_q, state_d;
   logic cnt_clr, cnt_inc, cnt_last;
   // only the edge the current state counts is ever fed to the counter
   assign cnt_clr = chipSelectN || state_q == S_IDLE || state_q == S_GOT_ADDR;
   assign cnt_inc = ((state_q == S_GET_ADDR || state_q == S_WRITE_RECV) && sclkPosEdge) ||
                    (state_q == S_READ_SHIFT && sclkNegEdge);
   spi_bit_counter #(.width(width)) u_cnt (
      .clk    (clk),
      .reset  (reset),
      .clear_i(cnt_clr),
      .inc_i  (cnt_inc),
      .last_o (cnt_last)
   );
   always_comb begin
      state_d = state_q;
      if (chipSelectN) state_d = S_IDLE;
      else
         case (state_q)
            S_IDLE:         state_d = S_GET_ADDR;
            S_GET_ADDR:     state_d = cnt_last ? S_GOT_ADDR : S_GET_ADDR;
            S_GOT_ADDR:     state_d = readWrite ? S_READ_LOAD : S_WRITE_RECV;
            S_READ_LOAD:    state_d = S_READ_SHIFT;
            S_READ_SHIFT:   state_d = cnt_last ? S_DONE : S_READ_SHIFT;
            S_WRITE_RECV:   state_d = cnt_last ? S_WRITE_COMMIT : S_WRITE_RECV;
            S_WRITE_COMMIT: state_d = S_DONE;
            default:        state_d = S_DONE;
         endcase
   end
   // outputs are registered from the next state so they stay Moore and glitch-free
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q            <= S_IDLE;
         addrLatchEnable    <= 1'b0;
         shiftRegLoad       <= 1'b0;
         misoBufferEnable   <= 1'b0;
         dataMemWriteEnable <= 1'b0;
      end else begin
         state_q            <= state_d;
         addrLatchEnable    <= state_d == S_GOT_ADDR;
         shiftRegLoad       <= state_d == S_READ_LOAD;
         misoBufferEnable   <= state_d == S_READ_SHIFT;
         dataMemWriteEnable <= state_d == S_WRITE_COMMIT;
      end
   end
endmodule

// File: tb/tb_spi_mem_fsm.sv
// tb_spi_mem_fsm: randomized transaction bench with an event scoreboard for spi_mem_fsm
module tb_spi_mem_fsm;
   typedef struct {
      int k;
      int t;
   } ev_t;
   localparam int EV_ALE = 0, EV_LOAD = 1, EV_DWE = 2, EV_RISE = 3, EV_FALL = 4;
   logic clk = 1'b0;
   logic reset = 1'b1, chipSelectN = 1'b1, sclkPosEdge = 1'b0, sclkNegEdge = 1'b0, readWrite = 1'b0;
   logic ale, load, mbe, dwe;
   int t = 0, passed = 0, total = 0, idx = 0, abort_at = -1, abort_kind = 0;
   bit mon_on = 0, mbe_prev = 0, mbe_exp = 0;
   ev_t exp_q[$];
   always #5 clk = ~clk;
   spi_mem_fsm #(.width(8)) dut (
      .clk               (clk),
      .reset             (reset),
      .chipSelectN       (chipSelectN),
      .sclkPosEdge       (sclkPosEdge),
      .sclkNegEdge       (sclkNegEdge),
      .readWrite         (readWrite),
      .addrLatchEnable   (ale),
      .shiftRegLoad      (load),
      .misoBufferEnable  (mbe),
      .dataMemWriteEnable(dwe)
   );
   function automatic logic rb();
      return logic'($urandom_range(0, 1));
   endfunction
   // inputs given to one tick are sampled at the next posedge; t then names that edge
   task automatic tick(input logic rs, input logic cs, input logic pe, input logic ne, input logic rw);
      reset = rs;
      chipSelectN = cs;
      sclkPosEdge = pe;
      sclkNegEdge = ne;
      readWrite = rw;
      @(posedge clk);
      #1;
      t++;
   endtask
   task automatic expect_ev(input int k);
      exp_q.push_back('{k, t});
   endtask
   task automatic check_ev(input int k);
      total++;
      if (exp_q.size() == 0)
         $display("FAIL event: got kind %0d at tick %0d, required no event", k, t);
      else begin
         ev_t e = exp_q.pop_front();
         if (e.k == k && e.t == t) passed++;
         else $display("FAIL event: got kind %0d at tick %0d, required kind %0d at tick %0d", k, t, e.k, e.t);
      end
   endtask
   always @(negedge clk) begin
      if (mon_on) begin
         if (ale) check_ev(EV_ALE);
         if (load) check_ev(EV_LOAD);
         if (dwe) check_ev(EV_DWE);
         if (mbe && !mbe_prev) check_ev(EV_RISE);
         if (!mbe && mbe_prev) check_ev(EV_FALL);
         mbe_prev = mbe;
      end
   end
   // one in-transfer tick, or the planned abort (CS rise or reset) followed by an idle tick
   task automatic step(input logic pe, input logic ne, input logic rw, output bit ab);
      ab = 0;
      if (idx == abort_at) begin
         ab = 1;
         if (abort_kind == 0) tick(1'b0, 1'b1, rb(), rb(), rb());
         else tick(1'b1, rb(), rb(), rb(), rb());
         if (mbe_exp) begin
            expect_ev(EV_FALL);
            mbe_exp = 0;
         end
         tick(1'b0, 1'b1, rb(), rb(), rb());
      end else tick(1'b0, 1'b0, pe, ne, rw);
      idx++;
   endtask
   task automatic transfer(input bit rw, input int ab_at, input int ab_kind, input int done_ticks);
      bit ab;
      int n;
      idx = 0;
      abort_at = ab_at;
      abort_kind = ab_kind;
      tick(1'b0, 1'b0, rb(), rb(), rb());
      n = 0;
      while (n < 8) begin
         logic pe = rb();
         step(pe, rb(), rb(), ab);
         if (ab) return;
         if (pe) n++;
      end
      expect_ev(EV_ALE);
      step(rb(), rb(), rw, ab);
      if (ab) return;
      if (rw) begin
         expect_ev(EV_LOAD);
         step(rb(), rb(), rb(), ab);
         if (ab) return;
         expect_ev(EV_RISE);
         mbe_exp = 1;
         n = 0;
         while (n < 8) begin
            logic ne = rb();
            step(rb(), ne, rb(), ab);
            if (ab) return;
            if (ne) n++;
         end
         expect_ev(EV_FALL);
         mbe_exp = 0;
      end else begin
         n = 0;
         while (n < 8) begin
            logic pe = rb();
            step(pe, rb(), rb(), ab);
            if (ab) return;
            if (pe) n++;
         end
         expect_ev(EV_DWE);
         step(rb(), rb(), rb(), ab);
         if (ab) return;
      end
      repeat (done_ticks) begin
         step(rb(), rb(), rb(), ab);
         if (ab) return;
      end
      tick(1'b0, 1'b1, rb(), rb(), rb());
   endtask
   task automatic check_idle(input string name);
      total++;
      if ({ale, load, mbe, dwe} == 4'b0000) passed++;
      else $display("FAIL %s: outputs ale/load/mbe/dwe = %b, required 0000", name, {ale, load, mbe, dwe});
   endtask
   initial begin
      tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      check_idle("reset_state");
      tick(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      check_idle("reset_override");
      tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      check_idle("idle_after_reset");
      mon_on = 1;
      transfer(1'b0, -1, 0, 4);
      transfer(1'b1, -1, 0, 4);
      transfer(1'b0, 6, 0, 2);
      transfer(1'b1, -1, 0, 2);
      transfer(1'b1, 22, 1, 2);
      transfer(1'b0, -1, 0, 3);
      transfer(1'b1, 40, 0, 60);
      for (int i = 0; i < 60; i++)
         transfer(rb(), ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 40)) : -1,
                  int'($urandom_range(0, 1)), int'($urandom_range(0, 5)));
      repeat (3) tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      mon_on = 0;
      check_idle("final_idle");
      total++;
      if (exp_q.size() == 0) passed++;
      else $display("FAIL pending_events: %0d expected events never seen, required 0 (first kind %0d at tick %0d)",
                    exp_q.size(), exp_q[0].k, exp_q[0].t);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
